ula_seq_32: RTL
===============

ULA_SEQ_32 -- requirements
Module: ula_seq_32

Interface
REQ-001 Parameter: BYTES, default 4, number of byte passes per operation (legal 1..8); datapath width W = 8*BYTES.
REQ-002 Ports (one clock; reset is synchronous and active-high):
  CLK  in  1  clock, all state updates on rising edge
  RST  in  1  synchronous active-high reset
  REQ0  in  1  requester 0 request level
  OP0  in  1  requester 0 operation: 0 = add, 1 = subtract (A-B)
  A0, B0  in  W  requester 0 operands
  REQ1, OP1, A1, B1  in  1/1/W/W  requester 1, same meaning
  GNT0, GNT1  out  1  one-cycle pulse: operands of that requester captured this cycle
  BUSY  out  1  high while an operation is in progress (grant cycle through DONE cycle)
  DONE  out  1  one-cycle pulse: RESULT and flags valid
  DONE_ID  out  1  requester served by the completing operation
  RESULT  out  W  sum/difference
  COUT  out  1  final carry out (subtract: 1 = no borrow)
  OVF  out  1  two's-complement signed overflow
  ZERO  out  1  RESULT == 0

Function
REQ-003 Byte arithmetic SHALL use one instance of the team's 8-bit ripple-carry adder full_adder_8_bits_structure, time-shared across all byte passes; no other adder in the datapath.
REQ-004 FSM states: IDLE, RUN, FIN.
REQ-005 IDLE: if REQ0 or REQ1 high, grant one, pulse its GNT, capture A, B' = (OP ? ~B : B), carry register = OP, byte index = 0, go RUN; else stay IDLE.
REQ-006 Arbitration: only one requester high -> grant it; both high -> grant the one not served last (round-robin); last-served register resets to 1 so REQ0 wins first tie.
REQ-007 Operands and OP are sampled only in the grant cycle; changes afterwards have no effect.
REQ-008 A requester holds REQ until its GNT; REQ dropped before grant yields no grant; REQ still high after GNT is treated as a new request.
REQ-009 RUN: each cycle adds byte k of A and B' with carry register; store sum into RESULT byte k, carry register <= adder COUT, k <= k+1; after byte BYTES-1 go FIN.
REQ-010 FIN: DONE = 1 for one cycle, DONE_ID = served requester, flags valid; next state IDLE (no grant in FIN).
REQ-011 Latency: grant at cycle T, byte passes T+1..T+BYTES, DONE at T+BYTES+1; earliest next grant T+BYTES+2.
REQ-012 COUT = carry out of byte BYTES-1; OVF = (A[W-1] == B'[W-1]) and (RESULT[W-1] != A[W-1]); ZERO = (RESULT == 0).
REQ-013 RESULT, COUT, OVF, ZERO, DONE_ID hold their values from DONE until the next DONE; RESULT bytes not yet written during RUN are don't-care and not observed by users until DONE.
REQ-014 GNT0 and GNT1 never high simultaneously; GNTx, DONE never high in the same cycle.
REQ-015 BUSY = 1 in the grant cycle, all RUN cycles and FIN; 0 otherwise.

Reset
REQ-016 RST high at a rising edge, in any state: next state IDLE; GNT0, GNT1, BUSY, DONE, DONE_ID, COUT, OVF, ZERO = 0; RESULT = 0; carry register, byte index = 0; last-served = 1.
REQ-017 RST mid-operation discards partial result and never produces DONE for the aborted operation; RST has priority over all requests in the same cycle.

Verification (BYTES = 4)
REQ-018 REQ0, OP0=0, A0=0x000000FF, B0=0x00000001 -> GNT0 at T, DONE at T+5, RESULT=0x00000100, COUT=0, OVF=0, ZERO=0, DONE_ID=0.
REQ-019 REQ1, OP1=1, A1=0x00000005, B1=0x00000005 -> RESULT=0x00000000, ZERO=1, COUT=1, OVF=0, DONE_ID=1.
REQ-020 ADD 0x7FFFFFFF+0x00000001 -> RESULT=0x80000000, OVF=1, COUT=0; ADD 0xFFFFFFFF+0x00000001 -> RESULT=0, COUT=1, ZERO=1, OVF=0.
REQ-021 SUB 0x00000000-0x00000001 -> RESULT=0xFFFFFFFF, COUT=0, OVF=0; SUB 0x80000000-0x00000001 -> RESULT=0x7FFFFFFF, OVF=1, COUT=1.
REQ-022 REQ0 and REQ1 held high from reset release -> grants alternate GNT0, GNT1, GNT0, ... every 6 cycles; DONE_ID alternates 0,1,0.
REQ-023 RST asserted in the cycle of byte pass 2 -> next cycle BUSY=0, all outputs 0, no DONE; a subsequent REQ1 ADD 0x00000010+0x00000020 completes normally with RESULT=0x00000030 five cycles after its grant.

Source files
------------

// File: rtl/ula_seq_32.sv
// ula_seq_32 -- byte-serial add/subtract unit shared by two requesters.
//
// One 8-bit ripple-carry adder is reused for every byte pass. A request
// is granted in IDLE, then BYTES passes run (LSB first) and the result
// and flags are presented with a one-cycle DONE pulse.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   REQx, OPx, Ax, Bx   requester x request level, op (0 add / 1 sub), operands
//   GNT0, GNT1          one-cycle grant pulse (operands captured this cycle)
//   BUSY                grant cycle through DONE cycle
//   DONE, DONE_ID       completion pulse and the requester it belongs to
//   RESULT, COUT,       result and flags, held from DONE until the next DONE
//   OVF, ZERO
//
// state | meaning
// IDLE  | waiting for a request; grant and capture operands
// RUN   | one byte pass per cycle through the shared adder
// FIN   | DONE pulse, result and flags valid

module full_adder_1_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module full_adder_8_bits_structure (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        full_adder_1_bit u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[8];
endmodule

module ula_seq_32 #(
    parameter int BYTES = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ0,
    input  logic                 OP0,
    input  logic [8*BYTES-1:0]   A0,
    input  logic [8*BYTES-1:0]   B0,
    input  logic                 REQ1,
    input  logic                 OP1,
    input  logic [8*BYTES-1:0]   A1,
    input  logic [8*BYTES-1:0]   B1,
    output logic                 GNT0,
    output logic                 GNT1,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 DONE_ID,
    output logic [8*BYTES-1:0]   RESULT,
    output logic                 COUT,
    output logic                 OVF,
    output logic                 ZERO
);
    localparam int W  = 8 * BYTES;
    localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            carry;
    logic [IW-1:0]   idx;
    logic            served;
    logic            last_served;

    logic            req_any;
    logic            sel1;
    logic            last_pass;
    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [7:0]      sum_byte;
    logic            add_cout;
    logic [W-1:0]    next_result;

    assign req_any   = REQ0 | REQ1;
    // Tie goes to whoever was not served last; last_served resets to 1.
    assign sel1      = REQ1 & (~REQ0 | ~last_served);
    assign last_pass = (idx == IW'(BYTES - 1));

    assign a_byte = a_reg[8*idx +: 8];
    assign b_byte = b_reg[8*idx +: 8];

    full_adder_8_bits_structure u_adder (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry),
        .sum  (sum_byte),
        .cout (add_cout)
    );

    // Result with the current pass's byte merged in; used so the flags
    // can be registered on the final pass edge and be valid during FIN.
    always_comb begin
        next_result = RESULT;
        next_result[8*idx +: 8] = sum_byte;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_any) next_state = RUN;
            RUN:     if (last_pass) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Grants are suppressed under reset so no capture is advertised for
    // a cycle in which reset wins.
    always_comb begin
        GNT0 = 1'b0;
        GNT1 = 1'b0;
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state)
            IDLE: begin
                if (req_any && !RST) begin
                    GNT0 = ~sel1;
                    GNT1 = sel1;
                    BUSY = 1'b1;
                end
            end
            RUN: BUSY = 1'b1;
            FIN: begin
                BUSY = 1'b1;
                DONE = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_reg       <= '0;
            b_reg       <= '0;
            carry       <= 1'b0;
            idx         <= '0;
            served      <= 1'b0;
            last_served <= 1'b1;
            RESULT      <= '0;
            COUT        <= 1'b0;
            OVF         <= 1'b0;
            ZERO        <= 1'b0;
            DONE_ID     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        a_reg       <= sel1 ? A1 : A0;
                        // Subtract as A + ~B + 1: invert B and seed carry with OP.
                        if (sel1) begin
                            b_reg <= OP1 ? ~B1 : B1;
                            carry <= OP1;
                        end else begin
                            b_reg <= OP0 ? ~B0 : B0;
                            carry <= OP0;
                        end
                        idx         <= '0;
                        served      <= sel1;
                        last_served <= sel1;
                    end
                end
                RUN: begin
                    RESULT <= next_result;
                    carry  <= add_cout;
                    idx    <= idx + 1'b1;
                    if (last_pass) begin
                        COUT    <= add_cout;
                        OVF     <= (a_reg[W-1] == b_reg[W-1]) &&
                                   (next_result[W-1] != a_reg[W-1]);
                        ZERO    <= (next_result == '0);
                        DONE_ID <= served;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
